// File: rtl/monitor_7seg_scan.sv
// rtl/monitor_7seg_scan.sv - scanned 7-segment display monitor and hex decoder
// Optional feature macro: DP_CAPTURE_EN (capture the decimal point into Puntos)
module monitor_7seg_scan #(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  Catodo,
  input  logic [3:0]  Seleccion,
  output logic [15:0] Digitos,
  output logic [3:0]  Digitos_validos,
  output logic [3:0]  Digitos_blancos,
  output logic [3:0]  Puntos,
  output logic        Frame_listo,
  output logic        Error_scan,
  output logic        Sin_senal
);

  localparam int TW_MIN = $clog2(TIMEOUT_CYCLES + 1);
  localparam int TW     = (TW_MIN > 17) ? TW_MIN : 17;
  localparam logic [7:0]    SETTLE  = 8'(SETTLE_CYCLES);
  localparam logic [TW-1:0] TIMEOUT = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_UPDATE  = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [3:0]    sel_q, sel_p;
  logic [6:0]    seg_q, seg_p;
  logic          legal_q, idle_q, illegal_q, stable_q;
  logic [7:0]    stab_cnt;
  logic          dwell_done;
  logic          capture;
  logic [3:0]    cap_oh;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_sat, timeout_drop;
  logic [3:0]    seen;
  logic          load_out;
  logic [6:0]    shadow_seg [4];
  logic [5:0]    dec [4];

  // Returns {valido, blanco, code} for an active-low segment pattern
  function automatic logic [5:0] seg_decode(input logic [6:0] seg);
    logic [5:0] r;
    case (seg)
      7'h40:   r = {2'b10, 4'h0};
      7'h79:   r = {2'b10, 4'h1};
      7'h24:   r = {2'b10, 4'h2};
      7'h30:   r = {2'b10, 4'h3};
      7'h19:   r = {2'b10, 4'h4};
      7'h12:   r = {2'b10, 4'h5};
      7'h02:   r = {2'b10, 4'h6};
      7'h78:   r = {2'b10, 4'h7};
      7'h00:   r = {2'b10, 4'h8};
      7'h10:   r = {2'b10, 4'h9};
      7'h08:   r = {2'b10, 4'hA};
      7'h03:   r = {2'b10, 4'hB};
      7'h46:   r = {2'b10, 4'hC};
      7'h21:   r = {2'b10, 4'hD};
      7'h06:   r = {2'b10, 4'hE};
      7'h0E:   r = {2'b10, 4'hF};
      7'h7F:   r = {2'b01, 4'h0};
      default: r = 6'b000000;
    endcase
    return r;
  endfunction

  // Input stage plus a one-cycle-delayed copy used by the stability compare
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q <= 4'hF;
      sel_p <= 4'hF;
      seg_q <= 7'h7F;
      seg_p <= 7'h7F;
    end else begin
      sel_q <= Seleccion;
      sel_p <= sel_q;
      seg_q <= Catodo[6:0];
      seg_p <= seg_q;
    end
  end

  // Classify the registered select pattern and test it for stability
  always_comb begin
    case (sel_q)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: legal_q = 1'b1;
      default:                            legal_q = 1'b0;
    endcase
    idle_q    = (sel_q == 4'hF);
    illegal_q = !legal_q && !idle_q;
    stable_q  = legal_q && (sel_q == sel_p) && (seg_q == seg_p);
    // sel_p/seg_p hold the pattern that produced the settled count
    capture   = (stab_cnt == SETTLE) && !dwell_done;
    cap_oh    = capture ? ~sel_p : 4'b0000;
    tmo_sat      = (tmo_cnt == TIMEOUT);
    timeout_drop = tmo_sat && !capture;
    load_out     = (state == ST_COLLECT) && (state_nx == ST_UPDATE);
  end

  // Stability filter; dwell_done blocks a second capture within one dwell
  always_ff @(posedge clk) begin
    if (rst) begin
      stab_cnt   <= 8'd0;
      dwell_done <= 1'b0;
    end else if (!legal_q) begin
      stab_cnt   <= 8'd0;
      dwell_done <= 1'b0;
    end else if (!stable_q) begin
      stab_cnt   <= 8'd1;
      dwell_done <= 1'b0;
    end else begin
      if (stab_cnt != SETTLE) stab_cnt <= stab_cnt + 8'd1;
      if (capture) dwell_done <= 1'b1;
    end
  end

  // Illegal select pattern reported one cycle after it is registered
  always_ff @(posedge clk) begin
    if (rst) Error_scan <= 1'b0;
    else     Error_scan <= illegal_q;
  end

  // Loss-of-scan timer, cleared by every capture, saturating
  always_ff @(posedge clk) begin
    if (rst)           tmo_cnt <= '0;
    else if (capture)  tmo_cnt <= '0;
    else if (!tmo_sat) tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign Sin_senal = tmo_sat;

  // Seen-mask; a capture on the frame-completion edge starts the next frame
  always_ff @(posedge clk) begin
    if (rst)               seen <= 4'b0000;
    else if (timeout_drop) seen <= 4'b0000;
    else if (load_out)     seen <= cap_oh;
    else                   seen <= seen | cap_oh;
  end

  // Shadow slots hold the raw segment pattern; latest capture wins
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) shadow_seg[i] <= 7'h7F;
    end else begin
      for (int i = 0; i < 4; i++)
        if (cap_oh[i]) shadow_seg[i] <= seg_p;
    end
  end

  // Decode each shadow slot
  always_comb begin
    for (int i = 0; i < 4; i++) dec[i] = seg_decode(shadow_seg[i]);
  end

  // Publish the completed frame on entry to UPDATE
  always_ff @(posedge clk) begin
    if (rst) begin
      Digitos         <= 16'h0000;
      Digitos_validos <= 4'b0000;
      Digitos_blancos <= 4'b0000;
    end else if (load_out) begin
      for (int i = 0; i < 4; i++) begin
        Digitos[4*i +: 4]  <= dec[i][3:0];
        Digitos_validos[i] <= dec[i][5];
        Digitos_blancos[i] <= dec[i][4];
      end
    end
  end

`ifdef DP_CAPTURE_EN
  logic       dp_q, dp_p;
  logic [3:0] shadow_dp;

  // Decimal point follows the segment pipeline but takes no part in stability
  always_ff @(posedge clk) begin
    if (rst) begin
      dp_q <= 1'b1;
      dp_p <= 1'b1;
    end else begin
      dp_q <= Catodo[7];
      dp_p <= dp_q;
    end
  end

  // Store lit decimal point per slot and publish it with the frame
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_dp <= 4'b0000;
      Puntos    <= 4'b0000;
    end else begin
      for (int i = 0; i < 4; i++)
        if (cap_oh[i]) shadow_dp[i] <= ~dp_p;
      if (load_out) Puntos <= shadow_dp;
    end
  end
`else
  logic unused_dp;
  assign unused_dp = Catodo[7];
  assign Puntos    = 4'b0000;
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // FSM next-state logic; loss of scan overrides everything
  always_comb begin
    state_nx = state;
    if (timeout_drop) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:    if (capture) state_nx = ST_COLLECT;
        ST_COLLECT: if (seen == 4'hF) state_nx = ST_UPDATE;
        ST_UPDATE:  state_nx = ST_COLLECT;
        default:    state_nx = ST_IDLE;
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    Frame_listo = (state == ST_UPDATE);
  end

endmodule

// File: tb/tb_monitor_7seg_scan.sv
// tb/tb_monitor_7seg_scan.sv - randomized bench with dwell-level reference model
`timescale 1ns/1ps
module tb_monitor_7seg_scan;

  localparam int S = 4;
  localparam int T = 300;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  Catodo;
  logic [3:0]  Seleccion;
  logic [15:0] Digitos;
  logic [3:0]  Digitos_validos;
  logic [3:0]  Digitos_blancos;
  logic [3:0]  Puntos;
  logic        Frame_listo;
  logic        Error_scan;
  logic        Sin_senal;

  always #5 clk = ~clk;

  monitor_7seg_scan #(.SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk),
    .rst(rst),
    .Catodo(Catodo),
    .Seleccion(Seleccion),
    .Digitos(Digitos),
    .Digitos_validos(Digitos_validos),
    .Digitos_blancos(Digitos_blancos),
    .Puntos(Puntos),
    .Frame_listo(Frame_listo),
    .Error_scan(Error_scan),
    .Sin_senal(Sin_senal)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: dwell-level view of the scanned display
  typedef struct {
    logic [15:0] dig;
    logic [3:0]  val;
    logic [3:0]  blk;
    logic [3:0]  dp;
  } frame_t;

  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  frame_t     exp_q [$];
  logic [7:0] m_slot [4];
  logic [3:0] seen_m;
  int         run;
  bit         prev_ok;
  logic [3:0] prev_sel;
  logic [7:0] prev_cat;
  int         since_cap;
  int         err_exp = 0;
  int         err_seen = 0;
  int         frames_seen = 0;

  function automatic frame_t make_frame();
    frame_t f;
    f.dig = '0; f.val = '0; f.blk = '0; f.dp = '0;
    for (int i = 0; i < 4; i++) begin
      for (int h = 0; h < 16; h++)
        if (m_slot[i][6:0] == glyph[h]) begin
          f.dig[4*i +: 4] = 4'(h);
          f.val[i] = 1'b1;
        end
      if (m_slot[i][6:0] == 7'h7F) f.blk[i] = 1'b1;
`ifdef DP_CAPTURE_EN
      f.dp[i] = ~m_slot[i][7];
`endif
    end
    return f;
  endfunction

  task automatic model_capture(input logic [3:0] sel, input logic [7:0] cat);
    for (int k = 0; k < 4; k++)
      if (!sel[k]) begin
        m_slot[k] = cat;
        seen_m[k] = 1'b1;
      end
    if (seen_m == 4'hF) begin
      exp_q.push_back(make_frame());
      seen_m = 4'h0;
    end
  endtask

  task automatic drive(input logic [3:0] sel, input logic [7:0] cat, input int len);
    int old;
    int off;
    if ($countones(~sel) == 1) begin
      old = (prev_ok && sel == prev_sel && cat[6:0] == prev_cat[6:0]) ? run : 0;
      run = old + len;
      prev_ok = 1'b1; prev_sel = sel; prev_cat = cat;
      if (old < S && run >= S) begin
        off = S - old;
        if (since_cap + off > T) seen_m = 4'h0;
        model_capture(sel, cat);
        since_cap = len - off;
      end else begin
        since_cap += len;
        if (since_cap > T) seen_m = 4'h0;
      end
    end else begin
      prev_ok = 1'b0; run = 0;
      if (sel != 4'hF) err_exp += len;
      since_cap += len;
      if (since_cap > T) seen_m = 4'h0;
    end
    Seleccion = sel;
    Catodo    = cat;
    repeat (len) @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1; Seleccion = 4'hF; Catodo = 8'hFF;
    seen_m = 4'h0; run = 0; prev_ok = 1'b0; since_cap = 0;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_digitos"}, 32'(Digitos), 32'h0);
    check({tag, "_validos"}, 32'(Digitos_validos), 32'h0);
    check({tag, "_blancos"}, 32'(Digitos_blancos), 32'h0);
    check({tag, "_puntos"},  32'(Puntos), 32'h0);
    check({tag, "_frame"},   32'(Frame_listo), 32'h0);
    check({tag, "_error"},   32'(Error_scan), 32'h0);
    check({tag, "_sin"},     32'(Sin_senal), 32'h0);
  endtask

  task automatic scan4(input logic [7:0] c0, input logic [7:0] c1,
                       input logic [7:0] c2, input logic [7:0] c3);
    drive(4'b1110, c0, 8);
    drive(4'b1101, c1, 8);
    drive(4'b1011, c2, 8);
    drive(4'b0111, c3, 8);
    drive(4'b1111, 8'hFF, 8);
  endtask

  // Frame and error monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (!rst) begin
      if (Error_scan) err_seen++;
      if (Frame_listo) begin
        frame_t f;
        frames_seen++;
        check("frame_expected", 32'(exp_q.size() > 0), 32'h1);
        if (exp_q.size() > 0) begin
          f = exp_q.pop_front();
          check("frame_digitos", 32'(Digitos), 32'(f.dig));
          check("frame_validos", 32'(Digitos_validos), 32'(f.val));
          check("frame_blancos", 32'(Digitos_blancos), 32'(f.blk));
          check("frame_puntos",  32'(Puntos), 32'(f.dp));
        end
      end
    end
  end

  initial begin
    int f0, e0, kind, len, k;
    bit last_illegal;
    logic [3:0] sel;
    logic [7:0] cat;
    logic [3:0] bad [11] = '{4'b1100, 4'b0000, 4'b1010, 4'b0011, 4'b1001, 4'b0101,
                             4'b0110, 4'b1000, 4'b0100, 4'b0010, 4'b0001};
    logic [3:0] exp_dp;

    for (int i = 0; i < 4; i++) m_slot[i] = 8'hFF;
    rst = 1'b1; Seleccion = 4'hF; Catodo = 8'hFF;
    repeat (2) @(negedge clk);
    apply_reset();
    check_reset_state("reset");

    // Basic 0..3 scan
    f0 = frames_seen;
    scan4(8'hC0, 8'hF9, 8'hA4, 8'hB0);
    check("t1_frames",  32'(frames_seen - f0), 32'h1);
    check("t1_digitos", 32'(Digitos), 32'h3210);
    check("t1_validos", 32'(Digitos_validos), 32'hF);

    // Blank in digit 2
    f0 = frames_seen;
    scan4(8'h92, 8'h92, 8'hFF, 8'h92);
    check("t2_frames",  32'(frames_seen - f0), 32'h1);
    check("t2_blancos", 32'(Digitos_blancos), 32'h4);
    check("t2_validos", 32'(Digitos_validos), 32'hB);
    check("t2_digit2",  32'(Digitos[11:8]), 32'h0);

    // Illegal select mid-scan
    f0 = frames_seen; e0 = err_seen;
    drive(4'b1110, 8'hC0, 8);
    drive(4'b1101, 8'hF9, 8);
    drive(4'b1100, 8'hFF, 1);
    drive(4'b1011, 8'hA4, 8);
    drive(4'b0111, 8'hB0, 8);
    drive(4'b1111, 8'hFF, 8);
    check("t3_errors",  32'(err_seen - e0), 32'h1);
    check("t3_frames",  32'(frames_seen - f0), 32'h1);
    check("t3_digitos", 32'(Digitos), 32'h3210);

    // Dwells too short to settle, until loss of scan
    f0 = frames_seen;
    for (int n = 0; n < T / 3 + 20; n++) begin
      sel = 4'hF; sel[n % 4] = 1'b0;
      drive(sel, 8'hC0, 3);
    end
    check("t4_sin_set", 32'(Sin_senal), 32'h1);
    check("t4_frames",  32'(frames_seen - f0), 32'h0);
    check("t4_digitos_hold", 32'(Digitos), 32'h3210);
    drive(4'b1110, 8'hC0, 8);
    check("t4_sin_clear", 32'(Sin_senal), 32'h0);

    // Reset after three of four digits captured
    drive(4'b1101, 8'hF9, 8);
    drive(4'b1011, 8'hA4, 8);
    apply_reset();
    check_reset_state("t5_reset");
    f0 = frames_seen;
    scan4(8'h99, 8'h92, 8'h82, 8'hF8);
    check("t5_frames",  32'(frames_seen - f0), 32'h1);
    check("t5_digitos", 32'(Digitos), 32'h7654);

    // Decimal point on digit 1
    scan4(8'hC0, 8'h79, 8'hA4, 8'hB0);
`ifdef DP_CAPTURE_EN
    exp_dp = 4'b0010;
`else
    exp_dp = 4'b0000;
`endif
    check("t6_puntos", 32'(Puntos), 32'(exp_dp));
    check("t6_digit1", 32'(Digitos[7:4]), 32'h1);

    // dp toggling inside a dwell must not split it
    f0 = frames_seen;
    drive(4'b1110, 8'hC0, 2);
    drive(4'b1110, 8'h40, 6);
    scan4(8'h40, 8'hF9, 8'hA4, 8'hB0);
`ifdef DP_CAPTURE_EN
    exp_dp = 4'b0001;
`else
    exp_dp = 4'b0000;
`endif
    check("t7_frames", 32'(frames_seen - f0), 32'h1);
    check("t7_puntos", 32'(Puntos), 32'(exp_dp));

    // Randomized dwells
    last_illegal = 1'b0;
    for (int n = 0; n < 120; n++) begin
      kind = $urandom_range(0, 99);
      if (last_illegal || kind < 78) begin
        k = $urandom_range(0, 3);
        sel = 4'hF; sel[k] = 1'b0;
        case ($urandom_range(0, 9))
          0, 1, 2, 3, 4, 5: cat = {1'($urandom), glyph[$urandom_range(0, 15)]};
          6, 7:             cat = {1'($urandom), 7'h7F};
          default:          cat = 8'($urandom);
        endcase
        if ($urandom_range(0, 9) == 0 && prev_ok) begin
          sel = prev_sel;
          cat = {~prev_cat[7], prev_cat[6:0]};
        end
        len = $urandom_range(1, 10);
        last_illegal = 1'b0;
        drive(sel, cat, len);
      end else if (kind < 90) begin
        last_illegal = 1'b0;
        drive(4'hF, 8'hFF, $urandom_range(1, 3));
      end else begin
        last_illegal = 1'b1;
        drive(bad[$urandom_range(0, 10)], 8'($urandom), 1);
      end
    end
    drive(4'hF, 8'hFF, 12);
    check("rand_errors",  32'(err_seen), 32'(err_exp));
    check("rand_pending", 32'(exp_q.size()), 32'h0);
    check("rand_sin",     32'(Sin_senal), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
